// File: rtl/lb_read_pipe.sv
// Localbus stage between the host-link gateway and the application: registered
// strobes, a fixed-latency read-return pipeline and a small local status region.
module lb_read_pipe #(
  parameter int          ADDR_W   = 24,
  parameter int          DATA_W   = 32,
  parameter int          READ_LAT = 3,
  parameter logic [31:0] MAGIC    = 32'h6c627270
) (
  input  logic              lb_clk,
  input  logic              lb_rst_n,
  input  logic              lb_strobe,
  input  logic              lb_rd,
  input  logic [ADDR_W-1:0] lb_addr,
  input  logic [DATA_W-1:0] lb_dout,
  output logic [DATA_W-1:0] lb_din,
  output logic              lb_rvalid,
  output logic [ADDR_W-1:0] app_addr,
  output logic [DATA_W-1:0] app_data,
  output logic              app_write,
  output logic              app_read,
  input  logic [DATA_W-1:0] app_din
);

  localparam logic [3:0] LOCAL_TAG = 4'hF;

  logic              is_local;
  logic [3:0]        off;
  logic              wr_evt;
  logic              rd_evt;
  logic              clr;
  logic [DATA_W-1:0] local_word;

  logic [ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [DATA_W-1:0] app_data_q, app_data_d;
  logic              app_write_q, app_write_d;
  logic              app_read_q, app_read_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [15:0]       rd_count_q, rd_count_d;
  logic [READ_LAT:0] pend_q, pend_d;
  logic [READ_LAT:0] loc_q, loc_d;
  logic [DATA_W-1:0] word_q [0:READ_LAT];
  logic [DATA_W-1:0] word_d [0:READ_LAT];
  logic [DATA_W-1:0] lb_din_q, lb_din_d;
  logic              lb_rvalid_q, lb_rvalid_d;

  // Decode the incoming transaction; the local word uses pre-increment counts
  always_comb begin
    is_local = (lb_addr[ADDR_W-1 -: 4] == LOCAL_TAG);
    off      = lb_addr[3:0];
    wr_evt   = lb_strobe & ~lb_rd;
    rd_evt   = lb_strobe & lb_rd;
    clr      = wr_evt & is_local & (off == 4'd2);
    case (off)
      4'd0:    local_word = DATA_W'({rd_count_q, wr_count_q});
      4'd1:    local_word = DATA_W'(MAGIC);
      default: local_word = {DATA_W{1'b0}};
    endcase
  end

  // Next state of the application-facing stage and the transaction counters
  always_comb begin
    app_addr_d  = app_addr_q;
    app_data_d  = app_data_q;
    app_write_d = wr_evt & ~is_local;
    app_read_d  = rd_evt & ~is_local;
    if (lb_strobe) begin
      app_addr_d = lb_addr;
      app_data_d = lb_dout;
    end else begin
      app_addr_d = app_addr_q;
      app_data_d = app_data_q;
    end
    if (clr) begin
      wr_count_d = 16'd0;
      rd_count_d = 16'd0;
    end else begin
      wr_count_d = wr_count_q + {15'd0, wr_evt};
      rd_count_d = rd_count_q + {15'd0, rd_evt};
    end
  end

  // Read-return shift register; the tail selects local or application data
  always_comb begin
    pend_d    = {pend_q[READ_LAT-1:0], rd_evt};
    loc_d     = {loc_q[READ_LAT-1:0], is_local};
    word_d[0] = local_word;
    for (int i = 1; i <= READ_LAT; i++) begin
      word_d[i] = word_q[i-1];
    end
    lb_rvalid_d = pend_q[READ_LAT];
    if (pend_q[READ_LAT]) begin
      lb_din_d = loc_q[READ_LAT] ? word_q[READ_LAT] : app_din;
    end else begin
      lb_din_d = lb_din_q;
    end
  end

  // State registers; reset discards any read in flight
  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      app_addr_q  <= {ADDR_W{1'b0}};
      app_data_q  <= {DATA_W{1'b0}};
      app_write_q <= 1'b0;
      app_read_q  <= 1'b0;
      wr_count_q  <= 16'd0;
      rd_count_q  <= 16'd0;
      pend_q      <= {(READ_LAT+1){1'b0}};
      loc_q       <= {(READ_LAT+1){1'b0}};
      for (int i = 0; i <= READ_LAT; i++) begin
        word_q[i] <= {DATA_W{1'b0}};
      end
      lb_din_q    <= {DATA_W{1'b0}};
      lb_rvalid_q <= 1'b0;
    end else begin
      app_addr_q  <= app_addr_d;
      app_data_q  <= app_data_d;
      app_write_q <= app_write_d;
      app_read_q  <= app_read_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      pend_q      <= pend_d;
      loc_q       <= loc_d;
      for (int i = 0; i <= READ_LAT; i++) begin
        word_q[i] <= word_d[i];
      end
      lb_din_q    <= lb_din_d;
      lb_rvalid_q <= lb_rvalid_d;
    end
  end

  assign app_addr  = app_addr_q;
  assign app_data  = app_data_q;
  assign app_write = app_write_q;
  assign app_read  = app_read_q;
  assign lb_din    = lb_din_q;
  assign lb_rvalid = lb_rvalid_q;

endmodule

// File: tb/tb_lb_read_pipe.sv
// Directed bench for lb_read_pipe: default-latency instance plus READ_LAT=1 and
// READ_LAT=15 instances sharing the localbus stimulus.
module tb_lb_read_pipe;

  logic        lb_clk = 1'b0;
  logic        lb_rst_n;
  logic        lb_strobe;
  logic        lb_rd;
  logic [23:0] lb_addr;
  logic [31:0] lb_dout;
  logic [31:0] app_din_s;
  logic [31:0] app_din_fix;

  logic [31:0] lb_din,    lb_din_l1,    lb_din_l15;
  logic        lb_rvalid, lb_rvalid_l1, lb_rvalid_l15;
  logic [23:0] app_addr,  app_addr_l1,  app_addr_l15;
  logic [31:0] app_data,  app_data_l1,  app_data_l15;
  logic        app_write, app_write_l1, app_write_l15;
  logic        app_read,  app_read_l1,  app_read_l15;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 lb_clk = ~lb_clk;

  lb_read_pipe dut (
    .lb_clk(lb_clk), .lb_rst_n(lb_rst_n), .lb_strobe(lb_strobe), .lb_rd(lb_rd),
    .lb_addr(lb_addr), .lb_dout(lb_dout), .lb_din(lb_din), .lb_rvalid(lb_rvalid),
    .app_addr(app_addr), .app_data(app_data), .app_write(app_write),
    .app_read(app_read), .app_din(app_din_s)
  );

  lb_read_pipe #(.READ_LAT(1)) dut_l1 (
    .lb_clk(lb_clk), .lb_rst_n(lb_rst_n), .lb_strobe(lb_strobe), .lb_rd(lb_rd),
    .lb_addr(lb_addr), .lb_dout(lb_dout), .lb_din(lb_din_l1), .lb_rvalid(lb_rvalid_l1),
    .app_addr(app_addr_l1), .app_data(app_data_l1), .app_write(app_write_l1),
    .app_read(app_read_l1), .app_din(app_din_fix)
  );

  lb_read_pipe #(.READ_LAT(15)) dut_l15 (
    .lb_clk(lb_clk), .lb_rst_n(lb_rst_n), .lb_strobe(lb_strobe), .lb_rd(lb_rd),
    .lb_addr(lb_addr), .lb_dout(lb_dout), .lb_din(lb_din_l15), .lb_rvalid(lb_rvalid_l15),
    .app_addr(app_addr_l15), .app_data(app_data_l15), .app_write(app_write_l15),
    .app_read(app_read_l15), .app_din(app_din_fix)
  );

  task automatic tick;
    @(posedge lb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    lb_rst_n = 1'b0;
    tick;
    tick;
    lb_rst_n = 1'b1;
    tick;
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d, input string tag);
    lb_strobe = 1'b1; lb_rd = 1'b0; lb_addr = a; lb_dout = d;
    tick;
    lb_strobe = 1'b0;
    chk({tag, "_app_write"}, app_write, a[23:20] != 4'hF);
    chk({tag, "_app_data"}, app_data, d);
    tick;
  endtask

  // Issues one read and waits (bounded) for its completion, checking latency and data.
  task automatic rd(input logic [23:0] a, input logic [31:0] exp, input string tag);
    int lat;
    lat = 0;
    lb_strobe = 1'b1; lb_rd = 1'b1; lb_addr = a;
    tick;
    lb_strobe = 1'b0; lb_rd = 1'b0;
    chk({tag, "_app_read"}, app_read, a[23:20] != 4'hF);
    chk({tag, "_app_write"}, app_write, 1'b0);
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (lb_rvalid) lat = c;
      else tick;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_data"}, lb_din, exp);
    tick;
    chk({tag, "_rvalid_drop"}, lb_rvalid, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lb_rst_n = 1'b0; lb_strobe = 1'b0; lb_rd = 1'b0; lb_addr = 24'h0; lb_dout = 32'h0;
    app_din_s = 32'h0; app_din_fix = 32'hA5A50001;

    // Reset state while held
    tick;
    lb_strobe = 1'b1; lb_rd = 1'b1; lb_addr = 24'h000044;
    tick;
    chk("rst_lb_din", lb_din, 32'h0);
    chk("rst_rvalid", lb_rvalid, 1'b0);
    chk("rst_app_addr", app_addr, 24'h0);
    chk("rst_app_data", app_data, 32'h0);
    chk("rst_app_write", app_write, 1'b0);
    chk("rst_app_read", app_read, 1'b0);
    lb_strobe = 1'b0; lb_rd = 1'b0;
    lb_rst_n = 1'b1;
    tick;
    tick;

    // App read, default latency
    lb_strobe = 1'b1; lb_rd = 1'b1; lb_addr = 24'h000010;
    tick;
    lb_strobe = 1'b0; lb_rd = 1'b0;
    chk("s1_c1_app_read", app_read, 1'b1);
    chk("s1_c1_app_addr", app_addr, 24'h000010);
    chk("s1_c1_rvalid", lb_rvalid, 1'b0);
    tick;
    chk("s1_c2_app_read", app_read, 1'b0);
    tick;
    tick;
    app_din_s = 32'hA5A50001;
    chk("s1_c4_rvalid", lb_rvalid, 1'b0);
    tick;
    app_din_s = 32'h0;
    chk("s1_c5_rvalid", lb_rvalid, 1'b1);
    chk("s1_c5_data", lb_din, 32'hA5A50001);
    tick;
    chk("s1_c6_rvalid", lb_rvalid, 1'b0);
    chk("s1_c6_hold", lb_din, 32'hA5A50001);
    tick;
    chk("s1_c7_hold", lb_din, 32'hA5A50001);

    // Back-to-back reads at cycles 0..3, data in cycles 4..7, returns in 5..8
    for (int c = 0; c <= 9; c++) begin
      lb_strobe = (c < 4);
      lb_rd     = (c < 4);
      lb_addr   = 24'(c);
      app_din_s = (c >= 4 && c <= 7) ? 32'h100 + 32'(c - 4) : 32'h0;
      if (c >= 1) chk("b2b_rvalid", lb_rvalid, (c >= 5 && c <= 8));
      if (c >= 5 && c <= 8) chk("b2b_data", lb_din, 32'h100 + 32'(c - 5));
      tick;
    end
    lb_strobe = 1'b0; lb_rd = 1'b0;

    // Counters: 3 writes, 2 reads, then local status reads
    do_reset;
    app_din_s = 32'hDEAD0000;
    wr(24'h000020, 32'h11111111, "cnt_w0");
    wr(24'h000021, 32'h22222222, "cnt_w1");
    wr(24'h000022, 32'h33333333, "cnt_w2");
    rd(24'h000030, 32'hDEAD0000, "cnt_r0");
    rd(24'h000031, 32'hDEAD0000, "cnt_r1");
    rd(24'hF00000, 32'h00020003, "cnt_status");
    rd(24'hF00001, 32'h6c627270, "cnt_magic");
    rd(24'hF00003, 32'h00000000, "cnt_off3");

    // Counter clear, then wrap of the write counter
    wr(24'hF00002, 32'hFFFFFFFF, "clr_w");
    rd(24'hF00000, 32'h00000000, "clr_status");
    for (int i = 0; i < 65537; i++) begin
      lb_strobe = 1'b1; lb_rd = 1'b0; lb_addr = 24'h000040; lb_dout = 32'(i);
      tick;
    end
    lb_strobe = 1'b0;
    tick;
    rd(24'hF00000, 32'h00010001, "wrap_status");
    wr(24'hF00007, 32'h12345678, "loc_w7");
    rd(24'hF00000, 32'h00020002, "loc_w7_status");

    // Reset mid-read: read at cycle 0, reset in cycle 2, release in cycle 3
    lb_strobe = 1'b1; lb_rd = 1'b1; lb_addr = 24'h000050;
    tick;
    lb_strobe = 1'b0; lb_rd = 1'b0;
    tick;
    lb_rst_n = 1'b0;
    lb_strobe = 1'b1; lb_rd = 1'b0; lb_addr = 24'h000060; lb_dout = 32'hCAFEF00D;
    #1;
    chk("mid_rst_lb_din", lb_din, 32'h0);
    chk("mid_rst_rvalid", lb_rvalid, 1'b0);
    chk("mid_rst_app_addr", app_addr, 24'h0);
    chk("mid_rst_app_read", app_read, 1'b0);
    tick;
    chk("mid_rst_app_write", app_write, 1'b0);
    chk("mid_rst_app_data", app_data, 32'h0);
    lb_strobe = 1'b0;
    lb_rst_n = 1'b1;
    for (int c = 3; c <= 10; c++) begin
      chk("mid_rst_no_rvalid", lb_rvalid, 1'b0);
      tick;
    end
    rd(24'hF00000, 32'h00000000, "mid_rst_status");

    // Latency parameter: default, READ_LAT=1 and READ_LAT=15 side by side
    do_reset;
    app_din_s = 32'hA5A50001;
    lb_strobe = 1'b1; lb_rd = 1'b1; lb_addr = 24'h000010;
    tick;
    lb_strobe = 1'b0; lb_rd = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      chk("lat3_rvalid", lb_rvalid, c == 5);
      chk("lat1_rvalid", lb_rvalid_l1, c == 3);
      chk("lat15_rvalid", lb_rvalid_l15, c == 17);
      if (c == 3) chk("lat1_data", lb_din_l1, 32'hA5A50001);
      if (c == 17) chk("lat15_data", lb_din_l15, 32'hA5A50001);
      tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lb_read_pipe.md
# lb_read_pipe

Fixed-latency localbus stage between the host-link gateway (`jxj_gate` on port 50006) and `application_top`. It registers the gateway's write/read strobes toward the application and runs a pipelined read-return path that tolerates one read per cycle. It also provides a small local status region with transaction counters. Every read therefore returns data a deterministic number of cycles after its strobe.

## Interface

Parameters:
- `ADDR_W`, 24: localbus address width.
- `DATA_W`, 32: localbus data width.
- `READ_LAT`, 3: application read latency in cycles, measured from `app_read` to valid `app_din`; legal range is 1..15.
- `MAGIC`, 32'h6c627270: constant returned at local offset 1.

Ports:
- `lb_clk` in 1: sole clock.
- `lb_rst_n` in 1: reset, asynchronous, active-low.
- `lb_strobe` in 1: transaction strobe from the gateway.
- `lb_rd` in 1: qualifies `lb_strobe` as a read.
- `lb_addr` in `ADDR_W`: transaction address.
- `lb_dout` in `DATA_W`: write data.
- `lb_din` out `DATA_W`: read data returned to the gateway.
- `lb_rvalid` out 1: one-cycle pulse marking `lb_din` updated.
- `app_addr` out `ADDR_W`: registered address toward the application.
- `app_data` out `DATA_W`: registered write data.
- `app_write` out 1: application write strobe.
- `app_read` out 1: application read strobe.
- `app_din` in `DATA_W`: application read data, valid `READ_LAT` cycles after `app_read`.

## Operation

Region decode:
- Local region: `lb_addr[ADDR_W-1:ADDR_W-4]==4'hF`, with `off = lb_addr[3:0]`.
- Application region: everything else.

Stage 1 (one register stage, all outputs registered):
- `app_addr` and `app_data` are loaded on every `lb_strobe`; they hold otherwise.
- `app_write = lb_strobe & ~lb_rd & app_region`.
- `app_read = lb_strobe & lb_rd & app_region`.
- Local-region accesses never assert `app_write` or `app_read`.

Read pipeline:
- A shift register of depth `READ_LAT+1` carries `{pending, is_local, local_word}`.
- `local_word` is computed at stage 1:
  - off 0: `{rd_count[15:0], wr_count[15:0]}`, sampled before this transaction's own increment.
  - off 1: `MAGIC`.
  - any other offset: 0.
- At the tail, when `pending` is set, `lb_din` loads `is_local ? local_word : app_din` and `lb_rvalid` pulses for one cycle.
- `lb_din` holds its value until the next read completes.
- A new read may be accepted every cycle. Reads complete in issue order, and writes interleave freely.

Counters:
- `wr_count` and `rd_count` are 16-bit and wrap from 0xFFFF to 0.
- They count every write and every read respectively, in any region, in the cycle `lb_strobe` is sampled.
- A local write to off 2 clears both counters; its data is ignored.
  - Clear has priority over the increment caused by that same write, leaving both counters at 0.
- Local writes to any other offset have no effect.

Reset (`lb_rst_n` low, asynchronous):
- `lb_din`, `lb_rvalid`, `app_addr`, `app_data`, `app_write`, `app_read`, both counters and all pipeline bits go to 0.
- A read in flight when reset asserts never produces `lb_rvalid`.
- Strobes present while `lb_rst_n` is low are ignored.

## Timing

- Cycle 0: `lb_strobe` is high. Cycle 1: `app_write` or `app_read` is high for exactly one cycle.
- `app_din` is sampled on the edge that ends cycle `1+READ_LAT`. `lb_rvalid` is high in cycle `2+READ_LAT`; with the default this is cycle 5.
- Local reads have identical latency to application reads.
- Counter reads reflect all transactions strobed strictly before the read's cycle 0.
- N back-to-back reads produce N consecutive `lb_rvalid` pulses, each carrying its own data.
- No combinational path exists from any input to any output.

## Test plan

- **App read, default latency.** Read 0x000010 at cycle 0, with `app_din=32'hA5A50001` presented in cycle 4. Required: `app_read` high in cycle 1 with `app_addr=0x000010`; `lb_rvalid` high in cycle 5 with `lb_din=32'hA5A50001`; `lb_din` held afterwards.
- **Back-to-back reads.** Four reads on consecutive cycles, addresses 0..3, with `app_din` returning 0x100+addr. Required: four consecutive `lb_rvalid` pulses with data 0x100..0x103, in order.
- **Counters.** Three writes, then two reads, then a local read of 0xF00000. Required: `lb_din=32'h00020003`. Then a local read of 0xF00001 returns `MAGIC`.
- **Counter clear.** Write 0xF00002, then read 0xF00000. Required: `lb_din=32'h00000000`; `app_write` is never asserted for either access.
- **Counter wrap.** 65537 writes, then a read of 0xF00000. Required: `wr_count` field = 1.
- **Reset mid-read.** Read issued at cycle 0, `lb_rst_n` pulled low in cycle 2 and released in cycle 3. Required: no `lb_rvalid` through cycle 10; all outputs 0 while reset is held.
- **Latency parameter.** Repeat the first scenario with `READ_LAT=1` and `READ_LAT=15`. Required: `lb_rvalid` in cycle 3 and cycle 17 respectively.
